// File: rtl/axis_pha_run_controller_if.sv
// AXI4-Stream style handshake bundle used on both sides of the run controller.
//   tdata  : pulse height
//   tvalid : beat valid (driven by master)
//   tready : beat ready (driven by slave)
interface axis_pha_run_controller_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_pha_run_controller.sv
// Pulse-height acquisition run controller.
// Gates the analyzer stream (s_axis) into the histogram stream (m_axis) for one
// run, applying a dead time after each accepted pulse, and ends the run on
// preset real time, preset event count, or a stop request.
// Ports:
//   aclk, aresetn      : clock, synchronous active-low reset
//   cfg_start          : level, rising edge starts a run (IDLE/DONE only)
//   cfg_stop           : level, forces end of run, blocks start
//   cfg_time/count/dead: presets (0 = unlimited for time/count)
//   s_axis (slave)     : pulse heights from analyzer
//   m_axis (master)    : forwarded pulse heights to histogram
//   sts_*              : run state and per-run counters
module axis_pha_run_controller #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int TIME_WIDTH       = 64,
  parameter int CNTR_WIDTH       = 32,
  parameter int DEAD_WIDTH       = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic [TIME_WIDTH-1:0]  cfg_time,
  input  logic [CNTR_WIDTH-1:0]  cfg_count,
  input  logic [DEAD_WIDTH-1:0]  cfg_dead,
  axis_pha_run_controller_if.slave  s_axis,
  axis_pha_run_controller_if.master m_axis,
  output logic [1:0]             sts_state,
  output logic [TIME_WIDTH-1:0]  sts_time,
  output logic [CNTR_WIDTH-1:0]  sts_count,
  output logic [CNTR_WIDTH-1:0]  sts_reject
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  state_e                      state_q, state_d;
  logic                        start_q;
  logic [TIME_WIDTH-1:0]       time_q, time_d;
  logic [CNTR_WIDTH-1:0]       count_q, count_d;
  logic [CNTR_WIDTH-1:0]       reject_q, reject_d;
  logic [DEAD_WIDTH-1:0]       dead_q, dead_d;
  logic                        mvld_q, mvld_d;
  logic [AXIS_TDATA_WIDTH-1:0] mdata_q, mdata_d;

  logic                  run, start_edge, do_start;
  logic                  s_rdy, beat, accept, reject;
  logic                  time_exp, count_exp;
  logic [CNTR_WIDTH-1:0] count_inc;

  assign run        = (state_q == ST_RUN);
  assign start_edge = cfg_start & ~start_q;
  assign do_start   = ~run & start_edge & ~cfg_stop;
  // Stop discards the beat offered in the same cycle, so it never reaches the
  // accept/reject logic.
  assign beat       = run & ~cfg_stop & s_axis.tvalid & s_rdy;
  assign accept     = beat & (dead_q == '0);
  assign reject     = beat & (dead_q != '0);
  assign count_inc  = count_q + CNTR_WIDTH'(1);
  assign time_exp   = (cfg_time != '0) & (time_q == cfg_time - TIME_WIDTH'(1));
  assign count_exp  = accept & (cfg_count != '0) & (count_inc == cfg_count);

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; stop wins over every other exit condition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (do_start) state_d = ST_RUN;
      ST_RUN:           if (cfg_stop | time_exp | count_exp) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Output logic: outside RUN the analyzer is drained unconditionally
  always_comb begin
    s_rdy = 1'b1;
    if (run && !cfg_stop) s_rdy = ~mvld_q | m_axis.tready;
  end

  // Datapath next-state
  always_comb begin
    time_d   = time_q;
    count_d  = count_q;
    reject_d = reject_q;
    dead_d   = (dead_q != '0) ? dead_q - DEAD_WIDTH'(1) : dead_q;
    mvld_d   = mvld_q;
    mdata_d  = mdata_q;
    if (do_start) begin
      time_d   = '0;
      count_d  = '0;
      reject_d = '0;
      dead_d   = '0;
    end else if (run) begin
      time_d = time_q + TIME_WIDTH'(1);
      if (accept) begin
        count_d = count_inc;
        dead_d  = cfg_dead;
      end
      if (reject && !(&reject_q)) reject_d = reject_q + CNTR_WIDTH'(1);
    end
    // Output register runs independently of state so a pending beat drains
    // after the run ends.
    if (accept) begin
      mvld_d  = 1'b1;
      mdata_d = s_axis.tdata;
    end else if (mvld_q && m_axis.tready) begin
      mvld_d  = 1'b0;
      mdata_d = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      start_q  <= 1'b0;
      time_q   <= '0;
      count_q  <= '0;
      reject_q <= '0;
      dead_q   <= '0;
      mvld_q   <= 1'b0;
      mdata_q  <= '0;
    end else begin
      start_q  <= cfg_start;
      time_q   <= time_d;
      count_q  <= count_d;
      reject_q <= reject_d;
      dead_q   <= dead_d;
      mvld_q   <= mvld_d;
      mdata_q  <= mdata_d;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = mvld_q;
  assign m_axis.tdata  = mdata_q;
  assign sts_state     = state_q;
  assign sts_time      = time_q;
  assign sts_count     = count_q;
  assign sts_reject    = reject_q;

endmodule

// File: tb/tb_axis_pha_run_controller.sv
// Bench for axis_pha_run_controller: directed table of runs with hand-derived
// end-of-run values, hand sequences for backpressure/stop/reset, then random
// traffic. Every cycle all outputs are compared against a transaction-level
// reference model.
module tb_axis_pha_run_controller;
  localparam int DW = 16, TW = 64, CW = 32, DDW = 16;

  logic          aclk = 1'b0, aresetn = 1'b0, cfg_start = 1'b0, cfg_stop = 1'b0;
  logic [TW-1:0] cfg_time = '0;
  logic [CW-1:0] cfg_count = '0;
  logic [DDW-1:0] cfg_dead = '0;
  logic [1:0]    sts_state;
  logic [TW-1:0] sts_time;
  logic [CW-1:0] sts_count, sts_reject;

  always #5 aclk = ~aclk;

  axis_pha_run_controller_if #(.DW(DW)) s_if ();
  axis_pha_run_controller_if #(.DW(DW)) m_if ();

  axis_pha_run_controller #(
    .AXIS_TDATA_WIDTH(DW), .TIME_WIDTH(TW), .CNTR_WIDTH(CW), .DEAD_WIDTH(DDW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_time(cfg_time), .cfg_count(cfg_count), .cfg_dead(cfg_dead),
    .s_axis(s_if), .m_axis(m_if),
    .sts_state(sts_state), .sts_time(sts_time), .sts_count(sts_count),
    .sts_reject(sts_reject)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (run-level bookkeeping) ----------------
  int            ms = 0;          // 0 idle, 1 running, 2 finished
  logic [63:0]   mt = '0;         // cycles run
  logic [31:0]   mc = '0, mr = '0;
  bit            prev_st = 1'b0;
  longint        cyc = 0;
  bit            acc_seen = 1'b0; // an acceptance happened in this run
  longint        acc_cyc = 0;
  longint        acc_dead = 0;
  logic [15:0]   oq[$];           // beats accepted but not yet taken downstream
  logic [15:0]   rx[$];           // beats actually delivered by the DUT
  bit            last_s_hs;

  function automatic bit m_srdy();
    return (ms != 1) || cfg_stop || (oq.size() == 0) || m_if.tready;
  endfunction

  task automatic model_step();
    bit rdy = m_srdy();
    bit edge_ = cfg_start && !prev_st;
    int nxt;
    cyc++;
    if (!aresetn) begin
      ms = 0; mt = '0; mc = '0; mr = '0; prev_st = 1'b0; acc_seen = 1'b0;
      oq.delete();
      return;
    end
    prev_st = cfg_start;
    if (oq.size() != 0 && m_if.tready) void'(oq.pop_front());
    if (ms == 1) begin
      nxt = 1;
      mt = mt + 64'd1;
      if (cfg_stop) nxt = 2;
      else begin
        if (cfg_time != 0 && mt == cfg_time) nxt = 2;
        if (s_if.tvalid && rdy) begin
          if (acc_seen && (cyc - acc_cyc <= acc_dead)) begin
            if (mr != 32'hFFFF_FFFF) mr = mr + 32'd1;
          end else begin
            oq.push_back(s_if.tdata);
            mc = mc + 32'd1;
            acc_seen = 1'b1; acc_cyc = cyc; acc_dead = longint'(cfg_dead);
            if (cfg_count != 0 && mc == cfg_count) nxt = 2;
          end
        end
      end
      ms = nxt;
    end else if (edge_ && !cfg_stop) begin
      ms = 1; mt = '0; mc = '0; mr = '0; acc_seen = 1'b0;
    end
  endtask

  // Called at a negedge after inputs are driven; returns at the next negedge.
  task automatic step();
    #1;
    chk("state",    64'(sts_state), 64'(ms));
    chk("time",     sts_time, mt);
    chk("count",    64'(sts_count), 64'(mc));
    chk("reject",   64'(sts_reject), 64'(mr));
    chk("s_tready", 64'(s_if.tready), 64'(m_srdy()));
    chk("m_tvalid", 64'(m_if.tvalid), 64'(oq.size() != 0));
    chk("m_tdata",  64'(m_if.tdata), 64'(oq.size() != 0 ? oq[0] : 16'd0));
    if (m_if.tvalid && m_if.tready) rx.push_back(m_if.tdata);
    last_s_hs = s_if.tvalid && s_if.tready;
    model_step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0; step(); step(); aresetn = 1'b1;
  endtask

  task automatic run_start();
    cfg_start = 1'b0; step();
    cfg_start = 1'b1; step();
    cfg_start = 1'b0;
  endtask

  typedef struct {
    logic [63:0] t; logic [31:0] c; logic [15:0] d;
    int period; int ncyc;
    int e_state; logic [63:0] e_time; logic [31:0] e_cnt; logic [31:0] e_rej;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{64'd100, 32'd0, 16'd0, 10, 120, 2, 64'd100, 32'd10, 32'd0};
    tbl[1] = '{64'd30,  32'd0, 16'd5, 1,  40,  2, 64'd30,  32'd5,  32'd25};
    tbl[2] = '{64'd0,   32'd3, 16'd0, 1,  10,  2, 64'd3,   32'd3,  32'd0};
    tbl[3] = '{64'd0,   32'd3, 16'd2, 1,  12,  2, 64'd7,   32'd3,  32'd4};
    tbl[4] = '{64'd5,   32'd5, 16'd0, 1,  8,   2, 64'd5,   32'd5,  32'd0};
    tbl[5] = '{64'd0,   32'd0, 16'd1, 1,  20,  1, 64'd20,  32'd10, 32'd10};

    s_if.tvalid = 1'b0; s_if.tdata = '0; m_if.tready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    chk("rst_state", 64'(sts_state), 64'd0);
    chk("rst_time", sts_time, 64'd0);
    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tdata", 64'(m_if.tdata), 64'd0);

    // Directed runs from the table
    for (int r = 0; r < 6; r++) begin
      do_reset();
      cfg_time = tbl[r].t; cfg_count = tbl[r].c; cfg_dead = tbl[r].d;
      m_if.tready = 1'b1; s_if.tvalid = 1'b0;
      run_start();
      for (int k = 0; k < tbl[r].ncyc; k++) begin
        s_if.tvalid = (k % tbl[r].period) == 0;
        s_if.tdata  = 16'(k + 1);
        step();
      end
      s_if.tvalid = 1'b0;
      chk($sformatf("tbl%0d_state", r), 64'(sts_state), 64'(tbl[r].e_state));
      chk($sformatf("tbl%0d_time", r), sts_time, tbl[r].e_time);
      chk($sformatf("tbl%0d_count", r), 64'(sts_count), 64'(tbl[r].e_cnt));
      chk($sformatf("tbl%0d_reject", r), 64'(sts_reject), 64'(tbl[r].e_rej));
    end

    // Backpressure: downstream stalls 20 cycles, nothing may be lost
    begin
      logic [15:0] src = 16'd1;
      do_reset();
      cfg_time = '0; cfg_count = '0; cfg_dead = '0;
      run_start();
      rx.delete();
      for (int k = 0; k < 26; k++) begin
        s_if.tvalid = 1'b1; s_if.tdata = src;
        m_if.tready = !(k >= 1 && k <= 20);
        step();
        if (last_s_hs) src = src + 16'd1;
        if (k == 20) begin
          #1;
          chk("bp_s_tready", 64'(s_if.tready), 64'd0);
          chk("bp_count", 64'(sts_count), 64'd1);
          chk("bp_tdata", 64'(m_if.tdata), 64'd1);
        end
      end
      s_if.tvalid = 1'b0; m_if.tready = 1'b1;
      chk("bp_count_after", 64'(sts_count), 64'd6);
      chk("bp_rx_len", 64'(rx.size()), 64'd5);
      for (int i = 0; i < rx.size() && i < 5; i++) chk("bp_rx_data", 64'(rx[i]), 64'(i + 1));
    end

    // Stop coinciding with time expiry and a valid beat; start blocked by stop
    do_reset();
    cfg_time = 64'd10; cfg_count = '0; cfg_dead = '0; m_if.tready = 1'b1;
    run_start();
    for (int k = 0; k < 10; k++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 16'(k + 1); cfg_stop = (k == 9);
      step();
    end
    s_if.tvalid = 1'b0;
    chk("stop_state", 64'(sts_state), 64'd2);
    chk("stop_time", sts_time, 64'd10);
    chk("stop_count", 64'(sts_count), 64'd9);
    chk("stop_reject", 64'(sts_reject), 64'd0);
    cfg_start = 1'b1; step(); step();
    chk("stop_blk_state", 64'(sts_state), 64'd2);
    chk("stop_blk_time", sts_time, 64'd10);
    cfg_start = 1'b0; cfg_stop = 1'b0; step();
    cfg_start = 1'b1; step();
    cfg_start = 1'b0;
    chk("restart_state", 64'(sts_state), 64'd1);
    chk("restart_time", sts_time, 64'd0);
    chk("restart_count", 64'(sts_count), 64'd0);

    // Reset mid-run with a pending output beat
    cfg_time = '0;
    m_if.tready = 1'b0; s_if.tvalid = 1'b1; s_if.tdata = 16'd7;
    step(); step();
    chk("mid_tvalid_pre", 64'(m_if.tvalid), 64'd1);
    aresetn = 1'b0; step(); aresetn = 1'b1;
    s_if.tvalid = 1'b0; m_if.tready = 1'b1;
    chk("mid_state", 64'(sts_state), 64'd0);
    chk("mid_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("mid_tdata", 64'(m_if.tdata), 64'd0);
    chk("mid_time", sts_time, 64'd0);
    chk("mid_count", 64'(sts_count), 64'd0);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        cfg_time  = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(5, 60));
        cfg_count = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
        cfg_dead  = 16'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 15) == 0) cfg_start = ~cfg_start;
      cfg_stop     = ($urandom_range(0, 49) == 0);
      s_if.tvalid  = $urandom_range(0, 1) == 1;
      s_if.tdata   = 16'($urandom);
      m_if.tready  = $urandom_range(0, 9) < 7;
      aresetn      = $urandom_range(0, 499) != 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
